// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// the load/store path; data wins unless fetch has been starved for a streak.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | no access outstanding, arbitrate every cycle
//   BUSY_IF | fetch access on the memory port
//   BUSY_DM | load/store access on the memory port
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [15:0]       if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              busy_o
);

    arb_state_t          state_q;
    arb_owner_t          win_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic                half_q;
    logic                drop_q;
    logic                if_rvalid_q, dm_rvalid_q;
    logic [15:0]         if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;

    logic arb_en, if_elig, streak_full, gnt_if, gnt_dm, done;

    assign done        = (state_q != IDLE) && mem_ready_i;
    assign arb_en      = !rst_i && ((state_q == IDLE) || mem_ready_i);
    assign if_elig     = if_req_i && !if_flush_i;
    assign streak_full = (streak_q == STREAK_W'(MAX_DM_STREAK));
    assign gnt_dm      = arb_en && dm_req_i && !(if_elig && streak_full);
    assign gnt_if      = arb_en && if_elig && !gnt_dm;
    assign win_d       = gnt_dm ? OWN_DM : OWN_IF;

    always_comb begin
        streak_d = streak_q;
        if (!if_req_i || gnt_if) begin
            streak_d = '0;
        end else if (gnt_dm && !streak_full) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            half_q      <= 1'b0;
            drop_q      <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            streak_q    <= streak_d;
            // A flush arriving in the completion cycle still kills the pulse.
            if_rvalid_q <= done && (state_q == BUSY_IF) && !drop_q && !if_flush_i;
            dm_rvalid_q <= done && (state_q == BUSY_DM);
            if (done && (state_q == BUSY_IF)) begin
                if_rdata_q <= half_q ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
            end
            if (done && (state_q == BUSY_DM)) begin
                dm_rdata_q <= mem_rdata_i;
            end
            if (done) begin
                drop_q <= 1'b0;
            end else if ((state_q == BUSY_IF) && if_flush_i) begin
                drop_q <= 1'b1;
            end
            if (gnt_dm || gnt_if) begin
                state_q <= (win_d == OWN_DM) ? BUSY_DM : BUSY_IF;
                addr_q  <= (win_d == OWN_DM) ? dm_addr_i : if_addr_i;
                we_q    <= (win_d == OWN_DM) && dm_we_i;
                wdata_q <= (win_d == OWN_DM) ? dm_wdata_i : '0;
                half_q  <= if_addr_i[1];
            end else if (done) begin
                state_q <= IDLE;
            end
        end
    end

    assign if_gnt_o    = gnt_if;
    assign dm_gnt_o    = gnt_dm;
    assign if_rvalid_o = if_rvalid_q;
    assign dm_rvalid_o = dm_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign busy_o      = (state_q != IDLE);
    assign mem_req_o   = busy_o;
    assign mem_we_o    = busy_o && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: requester queues drive the
// DUT, a monitor pops expected read data whenever an rvalid pulse appears.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_addr_i;
    logic [15:0] if_rdata_o;
    logic        dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
    logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic        mem_req_o, mem_we_o, mem_ready_i, busy_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
        .dm_rdata_o(dm_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: ready 'lat' cycles into each access, data derived from address.
    int lat = 1;
    bit hold = 1'b0;
    int mcnt = 0;
    always @(posedge clk_i) begin
        if (rst_i || !mem_req_o || mem_ready_i) mcnt <= 0;
        else mcnt <= mcnt + 1;
    end
    assign mem_ready_i = mem_req_o && !hold && (mcnt == lat - 1);
    assign mem_rdata_i = mem_ready_i ? {mem_addr_o[15:0] + 16'h1000, mem_addr_o[15:0]} : 32'h0;

    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } dm_req_t;
    typedef struct { bit chk; logic [31:0] data; } dm_exp_t;
    typedef struct {
        bit gi, gd, mreq, mwe, rdy, rvi, rvd;
        logic [31:0] maddr, mwdata;
    } tr_t;

    logic [31:0] if_reqs[$];
    dm_req_t     dm_reqs[$];
    logic [15:0] if_exp[$];
    dm_exp_t     dm_exp[$];
    tr_t         trace[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic drive();
        if_req_i   = (if_reqs.size() > 0);
        if_addr_i  = (if_reqs.size() > 0) ? if_reqs[0] : 32'h0;
        dm_req_i   = (dm_reqs.size() > 0);
        dm_we_i    = (dm_reqs.size() > 0) ? dm_reqs[0].we : 1'b0;
        dm_addr_i  = (dm_reqs.size() > 0) ? dm_reqs[0].addr : 32'h0;
        dm_wdata_i = (dm_reqs.size() > 0) ? dm_reqs[0].wdata : 32'h0;
    endtask

    task automatic tick();
        tr_t t;
        drive();
        @(negedge clk_i);
        t.gi = if_gnt_o; t.gd = dm_gnt_o; t.mreq = mem_req_o; t.mwe = mem_we_o;
        t.rdy = mem_ready_i; t.rvi = if_rvalid_o; t.rvd = dm_rvalid_o;
        t.maddr = mem_addr_o; t.mwdata = mem_wdata_o;
        trace.push_back(t);
        @(posedge clk_i);
        #1;
        if (t.gi && if_reqs.size() > 0) void'(if_reqs.pop_front());
        if (t.gd && dm_reqs.size() > 0) void'(dm_reqs.pop_front());
        drive();
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
        chk({tag, "_mem_req"}, {31'h0, mem_req_o}, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, mem_we_o}, 32'h0);
        chk({tag, "_gnts"}, {30'h0, if_gnt_o, dm_gnt_o}, 32'h0);
        chk({tag, "_rvalids"}, {30'h0, if_rvalid_o, dm_rvalid_o}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
        chk({tag, "_if_rdata"}, {16'h0, if_rdata_o}, 32'h0);
        chk({tag, "_dm_rdata"}, dm_rdata_o, 32'h0);
    endtask

    // Scoreboard monitor: every rvalid pulse must match the oldest expectation.
    always @(negedge clk_i) begin
        if (if_rvalid_o) begin
            if (if_exp.size() == 0) chk("if_rvalid_unexpected", 32'h1, 32'h0);
            else chk("if_rdata", {16'h0, if_rdata_o}, {16'h0, if_exp.pop_front()});
        end
        if (dm_rvalid_o) begin
            if (dm_exp.size() == 0) begin
                chk("dm_rvalid_unexpected", 32'h1, 32'h0);
            end else begin
                dm_exp_t e;
                e = dm_exp.pop_front();
                if (e.chk) chk("dm_rdata", dm_rdata_o, e.data);
                else chk("dm_store_done", {31'h0, dm_rvalid_o}, 32'h1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string g;
        bit    cont;
        rst_i = 1'b1; if_flush_i = 1'b0;
        drive();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("reset");
        @(posedge clk_i);
        #1;

        // Fetch only: addr 0x102 selects upper halfword, ready 2 cycles in.
        lat = 2; trace.delete();
        if_reqs.push_back(32'h102); if_exp.push_back(16'h1102);
        repeat (5) tick();
        chk("f_gnt_c0", {31'h0, trace[0].gi}, 32'h1);
        chk("f_mreq_c0", {31'h0, trace[0].mreq}, 32'h0);
        chk("f_mreq_c1c2", {30'h0, trace[1].mreq, trace[2].mreq}, 32'h3);
        chk("f_rvalid_c2", {31'h0, trace[2].rvi}, 32'h0);
        chk("f_rvalid_c3", {31'h0, trace[3].rvi}, 32'h1);
        chk("f_rvalid_c4", {31'h0, trace[4].rvi}, 32'h0);
        chk("f_mreq_c3", {31'h0, trace[3].mreq}, 32'h0);

        // Contention: load wins, fetch granted in the load's ready cycle.
        lat = 1; trace.delete();
        dm_reqs.push_back('{1'b0, 32'h200, 32'h0}); dm_exp.push_back('{1'b1, 32'h1200_0200});
        if_reqs.push_back(32'h104); if_exp.push_back(16'h0104);
        repeat (5) tick();
        chk("c_dm_gnt_c0", {30'h0, trace[0].gd, trace[0].gi}, 32'h2);
        chk("c_if_gnt_c1", {30'h0, trace[1].gd, trace[1].gi}, 32'h1);
        chk("c_mreq_c1c2", {30'h0, trace[1].mreq, trace[2].mreq}, 32'h3);
        chk("c_addr_c1", trace[1].maddr, 32'h200);
        chk("c_addr_c2", trace[2].maddr, 32'h104);

        // Starvation: two fetches held against ten loads, ready every cycle.
        trace.delete();
        if_reqs.push_back(32'h108); if_exp.push_back(16'h0108);
        if_reqs.push_back(32'h10A); if_exp.push_back(16'h110A);
        for (int i = 0; i < 10; i++) begin
            dm_reqs.push_back('{1'b0, 32'h300 + 32'(4 * i), 32'h0});
            dm_exp.push_back('{1'b1, {16'h1300 + 16'(4 * i), 16'h0300 + 16'(4 * i)}});
        end
        repeat (15) tick();
        g = "";
        cont = 1'b1;
        foreach (trace[i]) begin
            if (trace[i].gd) g = {g, "D"};
            if (trace[i].gi) g = {g, "I"};
            if (i >= 1 && i <= 12 && !trace[i].mreq) cont = 1'b0;
        end
        n_chk++;
        if (g == "DDDDIDDDDIDD") n_pass++;
        else $display("FAIL s_grant_order: got %s, want DDDDIDDDDIDD", g);
        chk("s_mreq_no_gap", {31'h0, cont}, 32'h1);

        // Flush during BUSY_IF, then a fetch vetoed by flush in IDLE.
        lat = 3; trace.delete();
        if_reqs.push_back(32'h110);
        tick(); tick();
        if_flush_i = 1'b1; tick();
        if_flush_i = 1'b0; tick(); tick();
        chk("fl_gnt", {31'h0, trace[0].gi}, 32'h1);
        chk("fl_mem_done", {30'h0, trace[3].mreq, trace[3].rdy}, 32'h3);
        chk("fl_no_rvalid", {31'h0, trace[4].rvi}, 32'h0);
        if_reqs.push_back(32'h112); if_exp.push_back(16'h1112);
        lat = 1;
        if_flush_i = 1'b1; tick();
        if_flush_i = 1'b0; tick();
        repeat (3) tick();
        chk("fl_veto", {31'h0, trace[5].gi}, 32'h0);
        chk("fl_regrant", {31'h0, trace[6].gi}, 32'h1);
        chk("fl_rvalid_next", {31'h0, trace[8].rvi}, 32'h1);

        // Store: write enable and data held stable until ready.
        lat = 3; trace.delete();
        dm_reqs.push_back('{1'b1, 32'h40, 32'hDEAD_BEEF}); dm_exp.push_back('{1'b0, 32'h0});
        repeat (6) tick();
        for (int i = 1; i <= 3; i++) begin
            chk("st_we", {31'h0, trace[i].mwe}, 32'h1);
            chk("st_addr", trace[i].maddr, 32'h40);
            chk("st_wdata", trace[i].mwdata, 32'hDEAD_BEEF);
        end
        chk("st_ready_c3", {31'h0, trace[3].rdy}, 32'h1);
        chk("st_rvalid_c4", {30'h0, trace[3].rvd, trace[4].rvd}, 32'h1);
        chk("st_idle_c4", {30'h0, trace[4].mreq, trace[4].mwe}, 32'h0);

        // Reset mid-access with ready withheld.
        hold = 1'b1; lat = 1; trace.delete();
        dm_reqs.push_back('{1'b0, 32'h80, 32'h0});
        repeat (3) tick();
        chk("rs_busy_before", {30'h0, trace[1].mreq, trace[2].mreq}, 32'h3);
        rst_i = 1'b1; tick();
        rst_i = 1'b0; hold = 1'b0;
        drive();
        @(negedge clk_i);
        check_all_zero("rs_after");
        @(posedge clk_i);
        #1;
        trace.delete();
        repeat (3) tick();
        foreach (trace[i]) chk("rs_no_rvalid", {30'h0, trace[i].rvd, trace[i].mreq}, 32'h0);

        chk("sb_if_empty", 32'(if_exp.size()), 32'h0);
        chk("sb_dm_empty", 32'(dm_exp.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
